// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl: collects 8 serial samples into a frame for the 8-point FFT core,
// holds the frame on core_vin while the core computes, then streams the 8 captured bins out.
// Optional framing check on s_last is enabled by defining FFT8_CTRL_TLAST_EN; without it,
// s_last is ignored and err stays 0.
//
// state | meaning
// FILL  | accepting input samples into ibuf
// WAIT  | frame stable on core_vin, counting core latency
// DRAIN | streaming captured bins on m_* with valid/ready
module fft8_frame_ctrl #(
    parameter int CORE_LAT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    output logic [255:0]     core_vin,
    input  logic [303:0]     core_vout,
    output logic [37:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [2:0]       m_index,
    output logic             m_last,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             err
);
    localparam int LAT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CORE_LAT - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       wcnt_q, wcnt_d;
    logic [2:0]       rcnt_q, rcnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [7:0][31:0] ibuf_q, ibuf_d;
    logic [7:0][37:0] obuf_q, obuf_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             err_q, err_d;
    logic             s_hs;
    logic             m_hs;

    assign s_hs = (state_q == FILL) && s_valid;
    assign m_hs = (state_q == DRAIN) && m_ready;

`ifndef FFT8_CTRL_TLAST_EN
    logic unused_s_last;
    assign unused_s_last = s_last;
`endif

    // Next-state, counter and buffer update logic.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        lat_d       = lat_q;
        ibuf_d      = ibuf_q;
        obuf_d      = obuf_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        unique case (state_q)
            FILL: begin
                if (s_hs) begin
                    ibuf_d[wcnt_q] = s_data;
`ifdef FFT8_CTRL_TLAST_EN
                    if (s_last && (wcnt_q != 3'd7)) begin
                        // early end-of-frame: drop the partial frame and restart
                        wcnt_d = 3'd0;
                        err_d  = 1'b1;
                    end else if (wcnt_q == 3'd7) begin
                        wcnt_d  = 3'd0;
                        lat_d   = '0;
                        state_d = WAIT;
                        if (!s_last) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        wcnt_d = wcnt_q + 3'd1;
                    end
`else
                    if (wcnt_q == 3'd7) begin
                        wcnt_d  = 3'd0;
                        lat_d   = '0;
                        state_d = WAIT;
                    end else begin
                        wcnt_d = wcnt_q + 3'd1;
                    end
`endif
                end
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    obuf_d  = core_vout;
                    rcnt_d  = 3'd0;
                    state_d = DRAIN;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            DRAIN: begin
                if (m_hs) begin
                    rcnt_d = rcnt_q + 3'd1;
                    if (rcnt_q == 3'd7) begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        state_d     = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= FILL;
            wcnt_q      <= 3'd0;
            rcnt_q      <= 3'd0;
            lat_q       <= '0;
            ibuf_q      <= '0;
            obuf_q      <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            lat_q       <= lat_d;
            ibuf_q      <= ibuf_d;
            obuf_q      <= obuf_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    assign core_vin  = ibuf_q;
    assign s_ready   = (state_q == FILL);
    assign m_valid   = (state_q == DRAIN);
    assign m_data    = m_valid ? obuf_q[rcnt_q] : 38'd0;
    assign m_index   = m_valid ? rcnt_q : 3'd0;
    assign m_last    = m_valid && (rcnt_q == 3'd7);
    assign busy      = (state_q == WAIT) || (state_q == DRAIN);
    assign frame_cnt = frame_cnt_q;
    assign err       = err_q;

endmodule
